// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default line timing and FSM encoding.
// Used by both the transmitter and the receiver.
package uart_pkg;

   localparam int DATA_BITS    = 8;
   localparam int CLK_FREQ_DEF = 27_000_000;
   localparam int BAUD_DEF     = 115_200;
   localparam int DIV_DEF      = CLK_FREQ_DEF / BAUD_DEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   // Integer-truncated clocks per bit.
   function automatic int bit_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   // Width of a counter that must reach div-1; never narrower than 1 bit.
   function automatic int cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO buffering bytes ahead of the serialiser.
// Pointers wrap modulo DEPTH; a push while full is dropped even if a pop occurs.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = DATA_BITS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok && !rst) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small input FIFO.
// Line and busy outputs are registered from the FSM state, one edge behind it.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = CLK_FREQ_DEF,
   parameter int BAUD       = BAUD_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_BITS-1:0]        tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        TxBit,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int DIV = bit_div(CLK_FREQ, BAUD);
   localparam int CW  = cnt_width(DIV);
   localparam int BW  = $clog2(DATA_BITS);

   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [BW-1:0] BIT_MAX = BW'(DATA_BITS - 1);

   uart_state_e          state_q;
   uart_state_e          state_d;
   logic [CW-1:0]        cnt_q;
   logic [CW-1:0]        cnt_d;
   logic [BW-1:0]        bit_q;
   logic [BW-1:0]        bit_d;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic                 txbit_d;
   logic                 busy_d;

   logic                 tick;
   logic                 pop;
   logic                 full;
   logic                 empty;
   logic [DATA_BITS-1:0] head;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_valid & tx_ready),
      .wdata (tx_data),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign tx_ready = ~full;
   assign tick     = (cnt_q == CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         TxBit   <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         TxBit   <= txbit_d;
         tx_busy <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               state_d = START;
            end
         end
         START: begin
            if (tick) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_MAX) state_d = STOP;
               else                  bit_d   = bit_q + 1'b1;
            end
         end
         STOP: begin
            if (tick) begin
               cnt_d = '0;
               // Chain straight into the next start bit when data waits.
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      txbit_d = 1'b1;
      busy_d  = 1'b0;
      case (state_q)
         START: begin
            txbit_d = 1'b0;
            busy_d  = 1'b1;
         end
         DATA: begin
            txbit_d = shift_q[0];
            busy_d  = 1'b1;
         end
         STOP: begin
            txbit_d = 1'b1;
            busy_d  = 1'b1;
         end
         default: begin
            txbit_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule
